ex_mem_seg_reg: RTL

- Pipeline segment register between the EX stage and the MEM/WB data stage that contains the data cache and the data-extension logic.
- Registers the ALU address, store data, load type and write-back select.
- Aligns store data and generates the 4-bit byte write-enable mask; flags misaligned accesses.
- Holds its contents while the data cache reports a miss, raises a stall request to the hazard unit, and keeps miss/access performance counters.

---
 rtl/ex_mem_seg_reg.sv | 119 +++++++++++
 1 files changed

// File: rtl/ex_mem_seg_reg.sv
// ex_mem_seg_reg: EX/MEM pipeline register with store alignment, miss hold and access counters
module ex_mem_seg_reg #(
  parameter int CNT_WIDTH         = 32,
  parameter bit MISALIGN_SUPPRESS = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bubbleM,
  input  logic                 flushM,
  input  logic [31:0]          alu_out_E,
  input  logic [31:0]          store_src_E,
  input  logic [1:0]           store_type_E,
  input  logic [2:0]           load_type_E,
  input  logic                 wb_select_E,
  input  logic                 cache_miss,
  output logic [31:0]          addr,
  output logic [31:0]          in_data,
  output logic [3:0]           write_en,
  output logic [2:0]           load_type,
  output logic                 wb_select,
  output logic                 miss_stall,
  output logic                 misalign_exc,
  output logic [CNT_WIDTH-1:0] access_cnt,
  output logic [CNT_WIDTH-1:0] miss_cnt,
  output logic [CNT_WIDTH-1:0] stall_cycle_cnt
);
  typedef enum logic {IDLE, MISS} state_t;
  state_t                state_q, state_d;
  logic [31:0]           addr_q, addr_d, in_data_q, in_data_d, data_e;
  logic [3:0]            write_en_q, write_en_d, be_e;
  logic [2:0]            load_type_q, load_type_d, lt_e;
  logic                  wb_select_q, wb_select_d, misalign_q, misalign_d;
  logic [CNT_WIDTH-1:0]  access_cnt_q, access_cnt_d, miss_cnt_q, miss_cnt_d, stall_cnt_q, stall_cnt_d;
  logic [1:0]            a;
  logic                  is_st, wb_e, mis_e, drop_e, access_valid, hold, miss_start, miss_done, hit_done;

  // A store wins over a simultaneous load: the load side is discarded
  always_comb begin
    a      = alu_out_E[1:0];
    is_st  = store_type_E != 2'd0;
    lt_e   = is_st ? 3'd0 : load_type_E;
    mis_e  = ((store_type_E == 2'd2 || lt_e == 3'd2 || lt_e == 3'd5) && a[0]) ||
             ((store_type_E == 2'd3 || lt_e == 3'd3) && a != 2'd0);
    drop_e = MISALIGN_SUPPRESS && mis_e;
    be_e   = drop_e                ? 4'b0000 :
             store_type_E == 2'd1 ? 4'b0001 << a :
             store_type_E == 2'd2 ? (a[1] ? 4'b1100 : 4'b0011) :
             store_type_E == 2'd3 ? 4'b1111 : 4'b0000;
    wb_e   = !is_st && wb_select_E && !drop_e;
    data_e = store_type_E == 2'd1 ? {4{store_src_E[7:0]}} :
             store_type_E == 2'd2 ? {2{store_src_E[15:0]}} : store_src_E;
  end

  assign access_valid = wb_select_q | (|write_en_q);
  assign miss_stall   = cache_miss & access_valid;
  assign hold         = miss_stall | bubbleM;

  // A pending miss outranks flush so the held access is never lost
  always_comb begin
    addr_d      = hold ? addr_q      : flushM ? 32'd0 : alu_out_E;
    in_data_d   = hold ? in_data_q   : flushM ? 32'd0 : data_e;
    write_en_d  = hold ? write_en_q  : flushM ? 4'd0  : be_e;
    load_type_d = hold ? load_type_q : flushM ? 3'd0  : lt_e;
    wb_select_d = hold ? wb_select_q : flushM ? 1'b0  : wb_e;
    misalign_d  = hold ? misalign_q  : flushM ? 1'b0  : mis_e;
  end

  always_comb begin
    state_d = state_q == IDLE ? (miss_stall ? MISS : IDLE) : (cache_miss ? MISS : IDLE);
  end

  always_comb begin
    miss_start = state_q == IDLE && miss_stall;
    miss_done  = state_q == MISS && !cache_miss;
    hit_done   = state_q == IDLE && access_valid && !cache_miss && !bubbleM;
  end

  always_comb begin
    access_cnt_d = access_cnt_q + CNT_WIDTH'(miss_done | hit_done);
    miss_cnt_d   = miss_cnt_q + CNT_WIDTH'(miss_start);
    stall_cnt_d  = stall_cnt_q + CNT_WIDTH'(miss_stall);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      in_data_q    <= '0;
      write_en_q   <= '0;
      load_type_q  <= '0;
      wb_select_q  <= 1'b0;
      misalign_q   <= 1'b0;
      access_cnt_q <= '0;
      miss_cnt_q   <= '0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      in_data_q    <= in_data_d;
      write_en_q   <= write_en_d;
      load_type_q  <= load_type_d;
      wb_select_q  <= wb_select_d;
      misalign_q   <= misalign_d;
      access_cnt_q <= access_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign addr            = addr_q;
  assign in_data         = in_data_q;
  assign write_en        = write_en_q;
  assign load_type       = load_type_q;
  assign wb_select       = wb_select_q;
  assign misalign_exc    = misalign_q;
  assign access_cnt      = access_cnt_q;
  assign miss_cnt        = miss_cnt_q;
  assign stall_cycle_cnt = stall_cnt_q;
endmodule
